config_int_add: RTL and testbench
=================================

CONFIG_INT_ADD -- requirements
Module: config_int_add

Interface
REQ-001 The block SHALL have parameter OP_BITWIDTH, default 32: operand width actually added.
REQ-002 The block SHALL have parameter DATA_PATH_BITWIDTH, default 32: port width, which SHALL be >= OP_BITWIDTH.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 32: width of the approximate-result counter.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-009 The block SHALL have ports a and b, input, DATA_PATH_BITWIDTH bits each: operands, of which only bits [OP_BITWIDTH-1:0] are used.
REQ-010 The block SHALL have port apx_ctl, input, 1 bit: 1 selects approximate mode, sampled per transaction.
REQ-011 The block SHALL have port sat_en, input, 1 bit: 1 selects signed saturation, sampled per transaction.
REQ-012 The block SHALL have port cfg_we, input, 1 bit: writes cfg_apx_bits into the config register.
REQ-013 The block SHALL have port cfg_apx_bits, input, $clog2(OP_BITWIDTH+1) bits: number of approximate LSBs (k).
REQ-014 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-016 The block SHALL have port c, output, DATA_PATH_BITWIDTH bits: result.
REQ-017 The block SHALL have port c_ovf, output, 1 bit: signed overflow of the OP_BITWIDTH sum.
REQ-018 The block SHALL have port apx_count, output, CNT_WIDTH bits: count of results delivered in approximate mode.

Function
REQ-019 An input transfer SHALL occur on a rising clk edge where in_valid && in_ready; an output transfer SHALL occur where out_valid && out_ready.
REQ-020 The pipeline SHALL have two register stages: S1 holds operands, apx_ctl, sat_en and k; S2 holds c, c_ovf and the mode flag; latency is 2 cycles from input transfer to out_valid when not stalled.
REQ-021 Each stage SHALL advance when it is empty or the downstream stage advances in the same cycle; in_ready = !S1_valid || S1 advances; sustained throughput is 1 per cycle with out_ready=1.
REQ-022 When out_ready=0, the block SHALL hold at most 2 transactions, keep c and c_ovf stable while out_valid=1, and deassert in_ready once both stages are full.
REQ-023 Exact sum (apx_ctl=0 or k=0): s = a[OP-1:0] + b[OP-1:0], modulo 2^OP_BITWIDTH.
REQ-024 Approximate sum (apx_ctl=1, k>0, lower-part OR): s[k-1:0] = a|b; s[OP-1:k] = a[OP-1:k] + b[OP-1:k] + (a[k-1] & b[k-1]).
REQ-025 When k >= OP_BITWIDTH, the block SHALL compute s = a|b over the full width with carry-in unused.
REQ-026 c_ovf SHALL equal (a[OP-1] == b[OP-1]) && (s[OP-1] != a[OP-1]), evaluated on s as computed.
REQ-027 When sat_en=1 and c_ovf=1, s SHALL be replaced by 0x7F..F if a[OP-1]=0, else 0x80..0; c_ovf SHALL still read 1.
REQ-028 c SHALL be s sign-extended from bit OP_BITWIDTH-1 to DATA_PATH_BITWIDTH.
REQ-029 cfg_we SHALL update k at the clock edge; input transfers in the same cycle SHALL use the old k; k is captured per transaction, so in-flight results are unaffected.
REQ-030 cfg_apx_bits values greater than OP_BITWIDTH SHALL be clamped to OP_BITWIDTH on write.
REQ-031 apx_count SHALL increment on each output transfer whose transaction had apx_ctl=1 and k>0, and SHALL saturate at all-ones.

Reset
REQ-032 While rst=1, the block SHALL force out_valid=0, in_ready=0, c=0, c_ovf=0, apx_count=0, k=0, and both stage-valid flags to 0.
REQ-033 Asserting rst mid-operation SHALL discard in-flight transactions; no output transfer SHALL occur for them after rst deasserts.
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-035 A shared package SHALL hold the default width constants, the k-width function ($clog2(OP_BITWIDTH+1)) and the S1 payload struct.
REQ-036 The combinational approximate adder SHALL be a sub-module named apx_loa_add, parametrised by OP_BITWIDTH, with inputs a, b, k and outputs s and ovf.
REQ-037 No other sub-modules SHALL be used.

Verification
REQ-038 Case k=4, apx_ctl=1, a=0x0000000F, b=0x00000001: c=0x0000000F, c_ovf=0; with apx_ctl=0: c=0x00000010.
REQ-039 Case a=0x7FFFFFFF, b=0x00000001, apx_ctl=0: with sat_en=1, c=0x7FFFFFFF and c_ovf=1; with sat_en=0, c=0x80000000 and c_ovf=1.
REQ-040 Case out_ready=0, in_valid=1 for 3 cycles: the bench SHALL see in_ready=0 after 2 accepts; on release, results SHALL appear in order with no loss or duplication.
REQ-041 Case cfg_we=1 with cfg_apx_bits=40 (OP=32), a=0xF0F0F0F0, b=0x0F0F0F0F: c=0xFFFFFFFF, c_ovf=0.
REQ-042 Case cfg_we in the same cycle as an input transfer, k changing 0->8, a=0xFF, b=0x01: that transaction SHALL give c=0x100; the next identical input SHALL give c=0xFF.
REQ-043 Case rst pulsed while out_valid=1 and apx_count=5: out_valid=0 and apx_count=0 immediately; no stale result SHALL appear afterwards.

Source files
------------

// File: rtl/config_int_add_pkg.sv
// Shared constants, helpers and types for the configurable approximate integer adder.
package config_int_add_pkg;

  localparam int DEF_OP_BITWIDTH        = 32;
  localparam int DEF_DATA_PATH_BITWIDTH = 32;
  localparam int DEF_CNT_WIDTH          = 32;

  // Width needed to encode k in 0..op_bitwidth inclusive.
  function automatic int k_width(input int op_bitwidth);
    return $clog2(op_bitwidth + 1);
  endfunction

  // Per-transaction mode captured in S1. The operands and k sit beside it because
  // their widths follow the instance parameters.
  typedef struct packed {
    logic apx_ctl;
    logic sat_en;
  } s1_payload_t;

endpackage

// File: rtl/apx_loa_add.sv
// Lower-part-OR approximate adder: k LSBs are OR-ed, the upper part adds exactly
// with a carry-in generated from the top approximate bit pair.
module apx_loa_add
  import config_int_add_pkg::*;
#(
  parameter int OP_BITWIDTH = DEF_OP_BITWIDTH
) (
  input  logic [OP_BITWIDTH-1:0]              a,
  input  logic [OP_BITWIDTH-1:0]              b,
  input  logic [k_width(OP_BITWIDTH)-1:0]     k,
  output logic [OP_BITWIDTH-1:0]              s,
  output logic                                ovf
);

  localparam int KW = k_width(OP_BITWIDTH);

  logic [OP_BITWIDTH-1:0] lo_mask;
  logic [OP_BITWIDTH-1:0] carry_vec;
  logic [OP_BITWIDTH-1:0] hi_sum;
  logic [OP_BITWIDTH-1:0] s_int;
  logic                   carry;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    carry_vec = '0;
    carry     = 1'b0;
    // A shift of k >= OP_BITWIDTH clears the ones, so the mask becomes all-ones.
    lo_mask   = ~({OP_BITWIDTH{1'b1}} << k);
    if (k != '0 && k < KW'(OP_BITWIDTH)) begin
      carry_vec = (a & b) >> (k - KW'(1));
      carry     = carry_vec[0];
    end
    hi_sum = (a & ~lo_mask) + (b & ~lo_mask) + (OP_BITWIDTH'(carry) << k);
    s_int  = (hi_sum & ~lo_mask) | ((a | b) & lo_mask);
  end

  assign s   = s_int;
  assign ovf = (a[OP_BITWIDTH-1] == b[OP_BITWIDTH-1]) &&
               (s_int[OP_BITWIDTH-1] != a[OP_BITWIDTH-1]);

endmodule

// File: rtl/config_int_add.sv
// Two-stage valid/ready adder with runtime-selectable approximation, optional
// signed saturation and a counter of approximate results delivered.
module config_int_add
  import config_int_add_pkg::*;
#(
  parameter int OP_BITWIDTH        = DEF_OP_BITWIDTH,
  parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH,
  parameter int CNT_WIDTH          = DEF_CNT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0]     a,
  input  logic [DATA_PATH_BITWIDTH-1:0]     b,
  input  logic                              apx_ctl,
  input  logic                              sat_en,
  input  logic                              cfg_we,
  input  logic [k_width(OP_BITWIDTH)-1:0]   cfg_apx_bits,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0]     c,
  output logic                              c_ovf,
  output logic [CNT_WIDTH-1:0]              apx_count
);

  localparam int            KW    = k_width(OP_BITWIDTH);
  localparam logic [KW-1:0] K_MAX = KW'(OP_BITWIDTH);

  logic [KW-1:0]             k_cfg;

  logic                      s1_valid;
  logic [OP_BITWIDTH-1:0]    s1_a;
  logic [OP_BITWIDTH-1:0]    s1_b;
  logic [KW-1:0]             s1_k;
  s1_payload_t               s1_mode;

  logic                      s2_valid;
  logic [DATA_PATH_BITWIDTH-1:0] s2_c;
  logic                      s2_ovf;
  logic                      s2_apx;
  logic [CNT_WIDTH-1:0]      cnt;

  logic                      s2_ready;
  logic                      s1_ready;
  logic [KW-1:0]             add_k;
  logic [OP_BITWIDTH-1:0]    add_s;
  logic                      add_ovf;
  logic [OP_BITWIDTH-1:0]    sat_s;

  // S2 can take new data when empty or emptying this cycle; S1 likewise behind it.
  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = !rst && s1_ready;
  assign out_valid = s2_valid;
  assign c         = s2_c;
  assign c_ovf     = s2_ovf;
  assign apx_count = cnt;

  assign add_k = s1_mode.apx_ctl ? s1_k : '0;

  apx_loa_add #(
    .OP_BITWIDTH (OP_BITWIDTH)
  ) u_apx_loa_add (
    .a   (s1_a),
    .b   (s1_b),
    .k   (add_k),
    .s   (add_s),
    .ovf (add_ovf)
  );

  always_comb begin
    sat_s = add_s;
    if (s1_mode.sat_en && add_ovf)
      sat_s = s1_a[OP_BITWIDTH-1] ? {1'b1, {(OP_BITWIDTH-1){1'b0}}}
                                  : {1'b0, {(OP_BITWIDTH-1){1'b1}}};
  end

  // Config register; a write coincident with an input transfer only affects later ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_cfg <= '0;
    end else if (cfg_we) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      k_cfg <= (cfg_apx_bits > K_MAX) ? K_MAX : cfg_apx_bits;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_k     <= '0;
      s1_mode  <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a            <= a[OP_BITWIDTH-1:0];
        s1_b            <= b[OP_BITWIDTH-1:0];
        s1_k            <= k_cfg;
        s1_mode.apx_ctl <= apx_ctl;
        s1_mode.sat_en  <= sat_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_c     <= '0;
      s2_ovf   <= 1'b0;
      s2_apx   <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_c   <= DATA_PATH_BITWIDTH'($signed(sat_s));
        s2_ovf <= add_ovf;
        s2_apx <= s1_mode.apx_ctl && (s1_k != '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (s2_valid && out_ready && s2_apx && !(&cnt))
      cnt <= cnt + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_config_int_add.sv
// Directed self-checking bench for config_int_add with default 32-bit widths.
module tb_config_int_add;
  import config_int_add_pkg::*;

  localparam int OP = 32;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam int KW = k_width(OP);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          apx_ctl;
  logic          sat_en;
  logic          cfg_we;
  logic [KW-1:0] cfg_apx_bits;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] c;
  logic          c_ovf;
  logic [CW-1:0] apx_count;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  config_int_add #(
    .OP_BITWIDTH        (OP),
    .DATA_PATH_BITWIDTH (DW),
    .CNT_WIDTH          (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .apx_ctl      (apx_ctl),
    .sat_en       (sat_en),
    .cfg_we       (cfg_we),
    .cfg_apx_bits (cfg_apx_bits),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .c            (c),
    .c_ovf        (c_ovf),
    .apx_count    (apx_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [KW-1:0] v);
    cfg_we       = 1'b1;
    cfg_apx_bits = v;
    tick();
    cfg_we       = 1'b0;
  endtask

  // One transaction with the consumer always ready; bounded waits on both handshakes.
  task automatic xact(input logic [31:0] ta, input logic [31:0] tb_v, input logic tapx,
                      input logic tsat, input logic [31:0] exp_c, input logic exp_ovf,
                      input string tag);
    int n;
    a = ta; b = tb_v; apx_ctl = tapx; sat_en = tsat;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_c"}, c, exp_c);
    check({tag, "_ovf"}, c_ovf, exp_ovf);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; apx_ctl = 1'b0; sat_en = 1'b0;
    cfg_we = 1'b0; cfg_apx_bits = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_c", c, 0);
    check("rst_ovf", c_ovf, 0);
    check("rst_cnt", apx_count, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    tick();

    // k=4, approximate: two-cycle latency and OR-ed low nibble.
    cfg_write(4);
    a = 32'h0000_000F; b = 32'h0000_0001; apx_ctl = 1'b1; sat_en = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat1_valid", out_valid, 0);
    tick();
    check("lat2_valid", out_valid, 1);
    check("apx4_c", c, 32'h0000_000F);
    check("apx4_ovf", c_ovf, 0);
    tick();
    check("cnt_after_apx4", apx_count, 1);

    xact(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0, "exact_lsb");
    check("cnt_after_exact", apx_count, 1);
    xact(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, "sat_pos");
    xact(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b1, "wrap_pos");
    xact(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b1, "sat_neg");
    xact(32'h0000_0018, 32'h0000_0008, 1'b1, 1'b0, 32'h0000_0028, 1'b0, "apx_carry");
    check("cnt_after_carry", apx_count, 2);

    // Backpressure: two accepts fill the pipe, third waits until release.
    out_ready = 1'b0; apx_ctl = 1'b0; sat_en = 1'b0;
    a = 32'd1; b = 32'd1; in_valid = 1'b1;
    #1;
    check("stall_rdy0", in_ready, 1);
    tick();
    a = 32'd2; b = 32'd2;
    #1;
    check("stall_rdy1", in_ready, 1);
    tick();
    a = 32'd3; b = 32'd3;
    #1;
    check("stall_full_rdy", in_ready, 0);
    check("stall_full_valid", out_valid, 1);
    check("stall_c0", c, 32'd2);
    tick();
    check("stall_hold_rdy", in_ready, 0);
    check("stall_hold_c", c, 32'd2);
    out_ready = 1'b1;
    #1;
    check("release_rdy", in_ready, 1);
    check("release_c0", c, 32'd2);
    tick();
    in_valid = 1'b0;
    check("drain1_valid", out_valid, 1);
    check("drain1_c", c, 32'd4);
    tick();
    check("drain2_valid", out_valid, 1);
    check("drain2_c", c, 32'd6);
    tick();
    check("drain_empty", out_valid, 0);

    // Oversized k clamps to full width: pure OR.
    cfg_write(6'd40);
    xact(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, "clamp_or");
    check("cnt_after_clamp", apx_count, 3);

    // Config write coincident with input transfer: that transaction keeps k=0.
    cfg_write(0);
    a = 32'h0000_00FF; b = 32'h0000_0001; apx_ctl = 1'b1; sat_en = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; cfg_we = 1'b1; cfg_apx_bits = 8;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    tick();
    check("oldk_valid", out_valid, 1);
    check("oldk_c", c, 32'h0000_0100);
    tick();
    check("cnt_oldk", apx_count, 3);
    xact(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_00FF, 1'b0, "newk");
    xact(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0003, 1'b0, "apx_small");
    check("cnt_five", apx_count, 5);

    // Reset with a result parked at the output.
    a = 32'd5; b = 32'd5; apx_ctl = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check("park_valid", out_valid, 1);
    check("park_c", c, 32'd10);
    check("park_cnt", apx_count, 5);
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_cnt", apx_count, 0);
    check("midrst_c", c, 0);
    check("midrst_rdy", in_ready, 0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale", out_valid, 0);
    end
    // k was cleared by reset, so an approximate request computes exactly.
    xact(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0100, 1'b0, "k_reset");
    check("cnt_k_reset", apx_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
